// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx : pops bytes from a circular buffer and sends them as UART frames
// Revision     : 1.0
// ============================================================================
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [2:0]          bit_q;
  logic [7:0]          shift_q;
  logic                par_q;
  logic                tx_q;
  logic                rd_en_q;
  logic                busy_q;
  logic [15:0]         frames_q;

  logic                baud_end;
  logic                stop_end;

  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign stop_end = baud_end && (bit_q == 3'(STOP_BITS - 1));

  // tx is loaded on the edge that enters each bit period, so it never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && !fifo_empty) begin
            state_q <= S_FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          rd_en_q <= 1'b0;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          shift_q <= fifo_rd_data;
          par_q   <= ^fifo_rd_data;
          tx_q    <= 1'b0;
          baud_q  <= '0;
          state_q <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (stop_end) begin
            baud_q   <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b0;
            frames_q <= frames_q + 16'd1;
            state_q  <= S_IDLE;
          end else if (baud_end) begin
            baud_q <= '0;
            bit_q  <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_fifo_uart_tx : drives three parameterisations of fifo_uart_tx from a shared buffer model
// Revision        : 1.0
// ============================================================================
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0]       en;
  logic             fifo_empty;
  logic [7:0]       rd_data = 8'h00;
  logic [2:0]       tx_w;
  logic [2:0]       rd_w;
  logic [2:0]       busy_w;
  logic [2:0][15:0] fs_w;

  int vec = 0;
  int miss = 0;
  int exp_fs [3];
  logic [7:0] mem [256];
  int push_cnt = 0;
  int pop_cnt = 0;
  int bad_pops = 0;

  // dut0: CPB=4/no parity/1 stop, dut1: CPB=4/parity/1 stop, dut2: CPB=2/no parity/2 stop
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(fifo_empty), .fifo_rd_data(rd_data),
    .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frames_sent(fs_w[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(fifo_empty), .fifo_rd_data(rd_data),
    .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frames_sent(fs_w[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .enable(en[2]), .fifo_empty(fifo_empty), .fifo_rd_data(rd_data),
    .fifo_rd_en(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frames_sent(fs_w[2]));

  // Buffer model: read data appears the cycle after the pop strobe
  assign fifo_empty = (push_cnt == pop_cnt);
  always @(posedge clk) begin
    if (|rd_w) begin
      if (push_cnt == pop_cnt) bad_pops <= bad_pops + 1;
      rd_data <= mem[pop_cnt[7:0]];
      pop_cnt <= pop_cnt + 1;
    end
  end

  function automatic int cpb(int k);    return (k == 2) ? 2 : 4; endfunction
  function automatic bit   par_on(int k); return (k == 1);        endfunction
  function automatic int stops(int k);  return (k == 2) ? 2 : 1; endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [7:0] b);
    mem[push_cnt[7:0]] = b;
    push_cnt++;
  endtask

  // Expected line: start, 8 data LSB first, optional even parity, stop bits; each bit held cpb cycles
  task automatic frame(int k, logic [7:0] b, bit b2b, bit drop_en);
    bit bits [$];
    int t;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par_on(k)) bits.push_back(bit'($countones(b) % 2));
    for (int s = 0; s < stops(k); s++) bits.push_back(1'b1);

    @(negedge clk);
    t = 0;
    if (b2b) chk("b2b_fetch_next_cycle", 32'(rd_w[k]), 32'd1);
    else while (!rd_w[k] && t < 200) begin @(negedge clk); t++; end
    chk("fetch_rd_en", 32'(rd_w[k]), 32'd1);
    chk("fetch_tx", 32'(tx_w[k]), 32'd1);
    chk("fetch_busy", 32'(busy_w[k]), 32'd1);
    @(negedge clk);
    chk("load_rd_en", 32'(rd_w[k]), 32'd0);
    chk("load_tx", 32'(tx_w[k]), 32'd1);
    chk("load_busy", 32'(busy_w[k]), 32'd1);
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < cpb(k); c++) begin
        @(negedge clk);
        chk($sformatf("dut%0d_byte%02h_bit%0d_tx", k, b, i), 32'(tx_w[k]), 32'(bits[i]));
        chk("frame_busy", 32'(busy_w[k]), 32'd1);
        chk("frame_rd_en", 32'(rd_w[k]), 32'd0);
      end
      if (drop_en && i == 2) en[k] = 1'b0;
    end
    @(negedge clk);
    exp_fs[k] = (exp_fs[k] + 1) % 65536;
    chk("idle_busy", 32'(busy_w[k]), 32'd0);
    chk("idle_tx", 32'(tx_w[k]), 32'd1);
    chk($sformatf("dut%0d_frames_sent", k), 32'(fs_w[k]), 32'(exp_fs[k]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb [4];
    int t;
    rst = 1'b1;
    en  = 3'b000;
    for (int k = 0; k < 3; k++) exp_fs[k] = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_tx", 32'(tx_w[k]), 32'd1);
      chk("reset_busy", 32'(busy_w[k]), 32'd0);
      chk("reset_rd_en", 32'(rd_w[k]), 32'd0);
      chk("reset_frames", 32'(fs_w[k]), 32'd0);
    end
    rst = 1'b0;

    // single byte
    @(negedge clk);
    push(8'hA5);
    en[0] = 1'b1;
    frame(0, 8'hA5, 1'b0, 1'b0);
    chk("single_pops", 32'(pop_cnt), 32'd1);

    // burst of fixed then random bytes, back to back
    push(8'h00); push(8'hFF); push(8'h3C);
    frame(0, 8'h00, 1'b0, 1'b0);
    frame(0, 8'hFF, 1'b1, 1'b0);
    frame(0, 8'h3C, 1'b1, 1'b0);
    chk("burst_frames", 32'(fs_w[0]), 32'd4);
    for (int i = 0; i < 4; i++) begin rb[i] = 8'($urandom); push(rb[i]); end
    for (int i = 0; i < 4; i++) frame(0, rb[i], i != 0, 1'b0);
    chk("burst_pops", 32'(pop_cnt), 32'(push_cnt));
    en[0] = 1'b0;

    // parity
    @(negedge clk);
    en[1] = 1'b1;
    push(8'h07); push(8'h03);
    rb[0] = 8'($urandom); rb[1] = 8'($urandom);
    push(rb[0]); push(rb[1]);
    frame(1, 8'h07, 1'b0, 1'b0);
    frame(1, 8'h03, 1'b1, 1'b0);
    frame(1, rb[0], 1'b1, 1'b0);
    frame(1, rb[1], 1'b1, 1'b0);
    en[1] = 1'b0;

    // enable control
    @(negedge clk);
    push(8'h55); push(8'h66);
    repeat (20) begin
      @(negedge clk);
      chk("disabled_no_pop", 32'(rd_w), 32'd0);
      chk("disabled_tx", 32'(tx_w), 32'd7);
    end
    en[0] = 1'b1;
    frame(0, 8'h55, 1'b0, 1'b1);
    repeat (30) begin
      @(negedge clk);
      chk("dropped_en_no_pop", 32'(rd_w), 32'd0);
      chk("dropped_en_tx", 32'(tx_w[0]), 32'd1);
    end
    chk("dropped_en_left", 32'(push_cnt - pop_cnt), 32'd1);
    en[0] = 1'b1;
    frame(0, 8'h66, 1'b0, 1'b0);

    // reset in the middle of data bit 3 of 8'hC3
    push(8'hC3);
    t = 0;
    @(negedge clk);
    while (!rd_w[0] && t < 200) begin @(negedge clk); t++; end
    chk("rst_case_fetch", 32'(rd_w[0]), 32'd1);
    repeat (19) @(negedge clk);
    chk("rst_case_bit3", 32'(tx_w[0]), 32'd0);
    chk("rst_case_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_tx", 32'(tx_w[0]), 32'd1);
    chk("rst_async_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_async_frames", 32'(fs_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) exp_fs[k] = 0;
    repeat (10) begin
      @(negedge clk);
      chk("rst_no_reread", 32'(rd_w), 32'd0);
    end
    chk("rst_pops", 32'(pop_cnt), 32'(push_cnt));
    push(8'h81);
    frame(0, 8'h81, 1'b0, 1'b0);
    en[0] = 1'b0;

    // two stop bits at 2 clocks per bit
    @(negedge clk);
    en[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin rb[i] = 8'($urandom); push(rb[i]); end
    for (int i = 0; i < 3; i++) frame(2, rb[i], i != 0, 1'b0);
    en[2] = 1'b0;

    chk("total_pops", 32'(pop_cnt), 32'(push_cnt));
    chk("no_pop_when_empty", 32'(bad_pops), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
